bullet_pool: RTL and testbench

BULLET_POOL -- requirements
Module: bullet_pool

---
 rtl/bullet_pool.sv | 177 +++++++++++++++++
 tb/tb_bullet_pool.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// bullet_pool: fixed pool of projectile slots advanced once per video frame.
// A rising edge on shoot, gated by a cooldown counter, launches the
// lowest-index free slot from the shooter's top edge. Slots retire on a
// collision hit or when they reach the playfield bounds. is_bullet is a
// combinational pixel test over every active slot.
// Optional build macro BULLET_POOL_AUTOFIRE_EN: a held shoot re-fires each
// time the cooldown expires.
module bullet_pool #(
    parameter int N_BULLETS = 4,
    parameter int X_MIN     = 170,
    parameter int X_MAX     = 469,
    parameter int SIZE      = 2,
    parameter int SPEED_X   = 4,
    parameter int SPEED_Y   = 10,
    parameter int COOLDOWN  = 8
) (
    input  logic                      Reset,
    input  logic                      frame_clk,
    input  logic                      shoot,
    input  logic [1:0]                direction,
    input  logic [9:0]                spawn_x,
    input  logic [9:0]                spawn_y,
    input  logic [9:0]                spawn_s,
    input  logic [N_BULLETS-1:0]      hit,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    output logic                      is_bullet,
    output logic [N_BULLETS-1:0]      active,
    output logic [10*N_BULLETS-1:0]   bullet_x,
    output logic [10*N_BULLETS-1:0]   bullet_y,
    output logic                      fire_ack,
    output logic                      fire_drop
);

    localparam logic [9:0]  X_MIN_C   = 10'(X_MIN);
    localparam logic [9:0]  X_MAX_C   = 10'(X_MAX);
    localparam logic [9:0]  SPD_Y_C   = 10'(SPEED_Y);
    localparam logic [10:0] SIZE_C    = 11'(SIZE);
    // The counter holds the number of frames still blocked after the
    // accepting frame, so shots are spaced exactly COOLDOWN frames apart.
    localparam logic [7:0]  CD_RELOAD = 8'(COOLDOWN - 1);

    logic                 prev_shoot_q;
    logic [7:0]           cooldown_q, cooldown_d;
    logic                 fire_ack_q, fire_drop_q;
    logic                 qualified, any_free, accept, drop;
    logic [N_BULLETS-1:0] grant;
    logic [N_BULLETS-1:0] in_box;
    logic [9:0]           spawn_vx, spawn_vy, spawn_top;

    // Shot qualification: edge-detected shoot (or level in autofire) with cooldown expired
    always_comb begin
`ifdef BULLET_POOL_AUTOFIRE_EN
        qualified = shoot && (cooldown_q == 8'd0);
`else
        qualified = shoot && !prev_shoot_q && (cooldown_q == 8'd0);
`endif
    end

    // Lowest-index free slot, judged on pre-edge occupancy only
    always_comb begin
        grant    = '0;
        any_free = 1'b0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (!active[i] && !any_free) begin
                grant[i] = 1'b1;
                any_free = 1'b1;
            end
        end
    end

    assign accept = qualified && any_free;
    assign drop   = qualified && !any_free;

    // Launch velocity from the direction code; code 3 behaves like straight up
    always_comb begin
        spawn_vx  = 10'd0;
        spawn_vy  = 10'(-SPEED_Y);
        spawn_top = spawn_y - spawn_s;
        case (direction)
            2'd1:    spawn_vx = 10'(-SPEED_X);
            2'd2:    spawn_vx = 10'(SPEED_X);
            default: spawn_vx = 10'd0;
        endcase
    end

    // Cooldown reloads only on an accepted shot, otherwise counts down to zero
    always_comb begin
        cooldown_d = cooldown_q;
        if (accept) begin
            cooldown_d = CD_RELOAD;
        end else if (cooldown_q != 8'd0) begin
            cooldown_d = cooldown_q - 8'd1;
        end
    end

    // Shared control registers
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            prev_shoot_q <= 1'b0;
            cooldown_q   <= 8'd0;
            fire_ack_q   <= 1'b0;
            fire_drop_q  <= 1'b0;
        end else begin
            prev_shoot_q <= shoot;
            cooldown_q   <= cooldown_d;
            fire_ack_q   <= accept;
            fire_drop_q  <= drop;
        end
    end

    assign fire_ack  = fire_ack_q;
    assign fire_drop = fire_drop_q;

    generate
        for (genvar gi = 0; gi < N_BULLETS; gi++) begin : g_slot
            logic       act_q, act_d;
            logic [9:0] x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
            logic       retire;

            assign retire = hit[gi] || (x_q >= X_MAX_C) || (x_q <= X_MIN_C) || (y_q <= SPD_Y_C);

            // Slot next state: fly-or-retire when occupied, launch when granted
            always_comb begin
                act_d = act_q;
                x_d   = x_q;
                y_d   = y_q;
                vx_d  = vx_q;
                vy_d  = vy_q;
                if (act_q) begin
                    if (retire) begin
                        act_d = 1'b0;
                    end else begin
                        x_d = x_q + vx_q;
                        y_d = y_q + vy_q;
                    end
                end else if (accept && grant[gi]) begin
                    act_d = 1'b1;
                    x_d   = spawn_x;
                    y_d   = spawn_top;
                    vx_d  = spawn_vx;
                    vy_d  = spawn_vy;
                end
            end

            // Slot state registers
            always_ff @(posedge frame_clk or posedge Reset) begin
                if (Reset) begin
                    act_q <= 1'b0;
                    x_q   <= 10'd0;
                    y_q   <= 10'd0;
                    vx_q  <= 10'd0;
                    vy_q  <= 10'd0;
                end else begin
                    act_q <= act_d;
                    x_q   <= x_d;
                    y_q   <= y_d;
                    vx_q  <= vx_d;
                    vy_q  <= vy_d;
                end
            end

            assign active[gi]             = act_q;
            assign bullet_x[10*gi +: 10]  = x_q;
            assign bullet_y[10*gi +: 10]  = y_q;
            // Box test widened to 11 bits so the +SIZE terms cannot wrap
            assign in_box[gi] = act_q
                && ({1'b0, DrawX} + SIZE_C >= {1'b0, x_q})
                && ({1'b0, DrawX} <= {1'b0, x_q} + SIZE_C)
                && ({1'b0, DrawY} + SIZE_C >= {1'b0, y_q})
                && ({1'b0, DrawY} <= {1'b0, y_q} + SIZE_C);
        end
    endgenerate

    assign is_bullet = |in_box;

endmodule

// File: tb/tb_bullet_pool.sv
// Testbench for bullet_pool: directed scenarios plus randomized frames
// compared against a frame-level behavioural model of the pool.
module tb_bullet_pool;
    localparam int N = 4;
    localparam int XMIN = 170, XMAX = 469, SZ = 2, SPX = 4, SPY = 10, CD = 8;

    logic Reset = 1'b1;
    logic frame_clk = 1'b0;
    logic shoot = 1'b0;
    logic [1:0] direction = 2'd0;
    logic [9:0] spawn_x = 10'd0, spawn_y = 10'd0, spawn_s = 10'd0;
    logic [N-1:0] hit = '0;
    logic [9:0] DrawX = 10'd0, DrawY = 10'd0;
    logic is_bullet, fire_ack, fire_drop;
    logic [N-1:0] active;
    logic [10*N-1:0] bullet_x, bullet_y;

    int checks = 0;
    int failures = 0;

    bullet_pool dut (
        .Reset(Reset), .frame_clk(frame_clk), .shoot(shoot), .direction(direction),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_s(spawn_s), .hit(hit),
        .DrawX(DrawX), .DrawY(DrawY), .is_bullet(is_bullet), .active(active),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .fire_ack(fire_ack), .fire_drop(fire_drop)
    );

    always #50 frame_clk = ~frame_clk;

    // Frame-level reference model
    bit m_act[N];
    int m_x[N], m_y[N], m_vx[N], m_vy[N];
    bit m_prev, m_ack, m_drop;
    int frame_no, last_acc;

    function automatic int wrap10(input int v);
        return ((v % 1024) + 1024) % 1024;
    endfunction

    function automatic logic [N-1:0] m_act_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_act[i];
        return v;
    endfunction

    function automatic bit m_is_bullet(input int dx, input int dy);
        bit r = 0;
        for (int i = 0; i < N; i++)
            if (m_act[i] && dx + SZ >= m_x[i] && dx <= m_x[i] + SZ && dy + SZ >= m_y[i] && dy <= m_y[i] + SZ)
                r = 1;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
        end
        m_prev = 0; m_ack = 0; m_drop = 0; frame_no = 0; last_acc = -1000;
    endtask

    // Drive one frame of inputs, advance the model, and land 1 time unit past the edge
    task automatic do_frame(input bit sh, input int dir, input int sx, input int sy, input int ss, input logic [N-1:0] hv);
        int fr;
        bit q;
        shoot = sh; direction = 2'(dir); spawn_x = 10'(sx); spawn_y = 10'(sy); spawn_s = 10'(ss); hit = hv;
        fr = -1;
        for (int i = 0; i < N; i++) if (!m_act[i] && fr < 0) fr = i;
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                if (hv[i] || m_x[i] >= XMAX || m_x[i] <= XMIN || m_y[i] <= SPY) m_act[i] = 0;
                else begin
                    m_x[i] = wrap10(m_x[i] + m_vx[i]);
                    m_y[i] = wrap10(m_y[i] + m_vy[i]);
                end
            end
        end
`ifdef BULLET_POOL_AUTOFIRE_EN
        q = sh && (frame_no - last_acc >= CD);
`else
        q = sh && !m_prev && (frame_no - last_acc >= CD);
`endif
        m_ack = q && (fr >= 0);
        m_drop = q && (fr < 0);
        if (m_ack) begin
            m_act[fr] = 1;
            m_x[fr] = wrap10(sx);
            m_y[fr] = wrap10(sy - ss);
            m_vx[fr] = (dir == 1) ? -SPX : (dir == 2) ? SPX : 0;
            m_vy[fr] = -SPY;
            last_acc = frame_no;
        end
        m_prev = sh;
        frame_no++;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset = 1'b1; shoot = 1'b0; hit = '0; direction = 2'd0;
        repeat (2) @(posedge frame_clk);
        #1;
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        DrawX = 10'd0; DrawY = 10'd0;
        #1;
        checks++; if (active !== '0) begin failures++; $display("FAIL reset_active: got %h expected 0", active); end
        checks++; if (fire_ack !== 1'b0 || fire_drop !== 1'b0) begin failures++; $display("FAIL reset_pulses: got ack=%b drop=%b expected 0/0", fire_ack, fire_drop); end
        checks++; if (bullet_x !== '0 || bullet_y !== '0) begin failures++; $display("FAIL reset_pos: got x=%h y=%h expected 0", bullet_x, bullet_y); end
        checks++; if (is_bullet !== 1'b0) begin failures++; $display("FAIL reset_is_bullet: got %b expected 0", is_bullet); end
        $display("test_reset done");
    endtask

    task automatic test_fire_up();
        apply_reset();
        do_frame(1, 0, 300, 400, 8, '0);
        checks++; if (fire_ack !== 1'b1) begin failures++; $display("FAIL up_ack: got %b expected 1", fire_ack); end
        checks++; if (active !== 4'b0001) begin failures++; $display("FAIL up_active: got %b expected 0001", active); end
        checks++; if (bullet_x[9:0] !== 10'd300 || bullet_y[9:0] !== 10'd392) begin failures++; $display("FAIL up_spawn: got (%0d,%0d) expected (300,392)", bullet_x[9:0], bullet_y[9:0]); end
        do_frame(0, 0, 300, 400, 8, '0);
        checks++; if (bullet_x[9:0] !== 10'd300 || bullet_y[9:0] !== 10'd382) begin failures++; $display("FAIL up_move: got (%0d,%0d) expected (300,382)", bullet_x[9:0], bullet_y[9:0]); end
        checks++; if (fire_ack !== 1'b0) begin failures++; $display("FAIL up_ack_pulse: got %b expected 0", fire_ack); end
        $display("test_fire_up done");
    endtask

    task automatic test_retire_edge();
        int exp_x[4] = '{464, 468, 472, 0};
        apply_reset();
        do_frame(1, 2, 460, 400, 8, '0);
        for (int k = 0; k < 4; k++) begin
            do_frame(0, 2, 460, 400, 8, '0);
            if (k < 3) begin
                checks++; if (active[0] !== 1'b1 || bullet_x[9:0] !== 10'(exp_x[k])) begin failures++; $display("FAIL retire_fly%0d: got act=%b x=%0d expected act=1 x=%0d", k, active[0], bullet_x[9:0], exp_x[k]); end
            end else begin
                checks++; if (active[0] !== 1'b0) begin failures++; $display("FAIL retire_x: got act=%b expected 0", active[0]); end
            end
        end
        $display("test_retire_edge done");
    endtask

    task automatic test_pool_full();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            do_frame(1, 0, 300, 1000, 0, '0);
            if (k < 4) begin
                checks++; if (fire_ack !== 1'b1 || active !== 4'((1 << (k + 1)) - 1)) begin failures++; $display("FAIL full_fill%0d: got ack=%b act=%b expected ack=1 act=%b", k, fire_ack, active, 4'((1 << (k + 1)) - 1)); end
            end else begin
                checks++; if (fire_drop !== 1'b1 || fire_ack !== 1'b0 || active !== 4'hF) begin failures++; $display("FAIL full_drop: got ack=%b drop=%b act=%b expected 0/1/1111", fire_ack, fire_drop, active); end
            end
            for (int j = 0; j < 9; j++) do_frame(0, 0, 300, 1000, 0, '0);
        end
        $display("test_pool_full done");
    endtask

    task automatic test_cooldown();
        int acks;
        int exp_acks;
        apply_reset();
        do_frame(1, 0, 300, 1000, 0, '0);
        checks++; if (fire_ack !== 1'b1) begin failures++; $display("FAIL cd_first: got %b expected 1", fire_ack); end
        do_frame(0, 0, 300, 1000, 0, '0);
        do_frame(0, 0, 300, 1000, 0, '0);
        do_frame(1, 0, 300, 1000, 0, '0);
        checks++; if (fire_ack !== 1'b0 || fire_drop !== 1'b0 || active !== 4'b0001) begin failures++; $display("FAIL cd_block: got ack=%b drop=%b act=%b expected 0/0/0001", fire_ack, fire_drop, active); end
        apply_reset();
        acks = 0;
`ifdef BULLET_POOL_AUTOFIRE_EN
        exp_acks = 3;
`else
        exp_acks = 1;
`endif
        for (int f = 0; f < 20; f++) begin
            do_frame(1, 0, 300, 1000, 0, '0);
            if (fire_ack === 1'b1) acks++;
`ifdef BULLET_POOL_AUTOFIRE_EN
            checks++; if (fire_ack !== ((f % 8) == 0)) begin failures++; $display("FAIL cd_auto_f%0d: got %b expected %b", f, fire_ack, (f % 8) == 0); end
`endif
        end
        checks++; if (acks !== exp_acks) begin failures++; $display("FAIL cd_hold: got %0d shots expected %0d", acks, exp_acks); end
        $display("test_cooldown done shots=%0d", acks);
    endtask

    task automatic test_hit_and_drop();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            do_frame(1, 0, 300, 1000, 0, '0);
            for (int j = 0; j < 9; j++) do_frame(0, 0, 300, 1000, 0, '0);
        end
        do_frame(1, 0, 300, 1000, 0, 4'b0100);
        checks++; if (active !== 4'b1011 || fire_drop !== 1'b1 || fire_ack !== 1'b0) begin failures++; $display("FAIL hitdrop_same: got act=%b drop=%b ack=%b expected 1011/1/0", active, fire_drop, fire_ack); end
        for (int j = 0; j < 9; j++) do_frame(0, 0, 300, 1000, 0, '0);
        do_frame(1, 0, 250, 1000, 0, '0);
        checks++; if (active !== 4'hF || fire_ack !== 1'b1 || bullet_x[29:20] !== 10'd250) begin failures++; $display("FAIL hitdrop_refill: got act=%b ack=%b x2=%0d expected 1111/1/250", active, fire_ack, bullet_x[29:20]); end
        $display("test_hit_and_drop done");
    endtask

    task automatic test_is_bullet();
        apply_reset();
        do_frame(1, 0, 300, 208, 8, '0);
        DrawY = 10'd200;
        for (int dx = 296; dx <= 304; dx++) begin
            DrawX = 10'(dx);
            #1;
            checks++; if (is_bullet !== (dx >= 298 && dx <= 302)) begin failures++; $display("FAIL box_x%0d: got %b expected %b", dx, is_bullet, dx >= 298 && dx <= 302); end
        end
        DrawX = 10'd300;
        for (int dy = 196; dy <= 204; dy++) begin
            DrawY = 10'(dy);
            #1;
            checks++; if (is_bullet !== (dy >= 198 && dy <= 202)) begin failures++; $display("FAIL box_y%0d: got %b expected %b", dy, is_bullet, dy >= 198 && dy <= 202); end
        end
        $display("test_is_bullet done");
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        do_frame(1, 1, 320, 300, 5, '0);
        do_frame(0, 1, 320, 300, 5, '0);
        Reset = 1'b1;
        #1;
        checks++; if (active !== '0 || bullet_x !== '0 || bullet_y !== '0) begin failures++; $display("FAIL async_reset: got act=%b x=%h y=%h expected all 0", active, bullet_x, bullet_y); end
        apply_reset();
        do_frame(1, 0, 300, 400, 8, '0);
        checks++; if (fire_ack !== 1'b1 || active !== 4'b0001) begin failures++; $display("FAIL post_reset_fire: got ack=%b act=%b expected 1/0001", fire_ack, active); end
        $display("test_reset_midflight done");
    endtask

    task automatic test_random();
        int r, dx, dy;
        apply_reset();
        for (int f = 0; f < 800; f++) begin
            do_frame(($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(150, 490),
                     $urandom_range(20, 500), $urandom_range(0, 15),
                     N'({$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0}));
            checks++; if (active !== m_act_vec() || fire_ack !== m_ack || fire_drop !== m_drop) begin failures++; $display("FAIL rand_ctrl f%0d: got act=%b ack=%b drop=%b expected act=%b ack=%b drop=%b", f, active, fire_ack, fire_drop, m_act_vec(), m_ack, m_drop); end
            for (int i = 0; i < N; i++) begin
                if (m_act[i]) begin
                    checks++; if (bullet_x[10*i +: 10] !== 10'(m_x[i]) || bullet_y[10*i +: 10] !== 10'(m_y[i])) begin failures++; $display("FAIL rand_pos f%0d s%0d: got (%0d,%0d) expected (%0d,%0d)", f, i, bullet_x[10*i +: 10], bullet_y[10*i +: 10], m_x[i], m_y[i]); end
                end
            end
            r = $urandom_range(0, N - 1);
            dx = wrap10(m_x[r] + $urandom_range(0, 8) - 4);
            dy = wrap10(m_y[r] + $urandom_range(0, 8) - 4);
            DrawX = 10'(dx); DrawY = 10'(dy);
            #1;
            checks++; if (is_bullet !== m_is_bullet(dx, dy)) begin failures++; $display("FAIL rand_box f%0d: got %b expected %b at (%0d,%0d)", f, is_bullet, m_is_bullet(dx, dy), dx, dy); end
        end
        $display("test_random done frames=800");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fire_up();
        test_retire_edge();
        test_pool_full();
        test_cooldown();
        test_hit_and_drop();
        test_is_bullet();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
